// File: rtl/sysid_boot_checker.sv
// Boot-time system ID checker: reads the sysid ID (and optionally timestamp) words, compares them, retries up to MAX_TRIES.
// Define SYSID_CHECK_TS_EN to also read and compare the build timestamp word.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1455550170,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned MAX_TRIES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic [2:0]  tries
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    WT_ID = 3'd2,
    RD_TS = 3'd3,
    WT_TS = 3'd4,
    CHECK = 3'd5,
    FIN   = 3'd6
  } state_t;

`ifdef SYSID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam logic [2:0] LAT      = 3'(READ_LATENCY);
  localparam logic [2:0] MAXT     = 3'(MAX_TRIES);
  localparam state_t     AFTER_ID = TS_EN ? RD_TS : CHECK;

  state_t      state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic [2:0]  tries_q, tries_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        ok_q, ok_d;
  logic        addr_q;
  logic        match;

  assign match = (id_q == EXPECTED_ID) && (!TS_EN || (ts_q == EXPECTED_TS));

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    tries_d       = tries_q;
    id_d          = id_q;
    ts_d          = ts_q;
    ok_d          = ok_q;
    sysid_read    = 1'b0;
    sysid_address = addr_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          ok_d    = 1'b0;
          tries_d = 3'd0;
          state_d = RD_ID;
        end
      end
      RD_ID: begin
        sysid_read    = 1'b1;
        sysid_address = 1'b0;
        tries_d       = tries_q + 3'd1;
        if (LAT == 3'd0) begin
          id_d    = sysid_readdata;
          state_d = AFTER_ID;
        end else begin
          lat_d   = 3'd1;
          state_d = WT_ID;
        end
      end
      WT_ID: begin
        // lat_q counts cycles since the read strobe; capture when it equals the latency
        if (lat_q == LAT) begin
          id_d    = sysid_readdata;
          lat_d   = 3'd0;
          state_d = AFTER_ID;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      RD_TS: begin
        sysid_read    = 1'b1;
        sysid_address = 1'b1;
        if (LAT == 3'd0) begin
          ts_d    = sysid_readdata;
          state_d = CHECK;
        end else begin
          lat_d   = 3'd1;
          state_d = WT_TS;
        end
      end
      WT_TS: begin
        if (lat_q == LAT) begin
          ts_d    = sysid_readdata;
          lat_d   = 3'd0;
          state_d = CHECK;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      CHECK: begin
        if (match) begin
          ok_d    = 1'b1;
          state_d = FIN;
        end else if (tries_q < MAXT) begin
          state_d = RD_ID;
        end else begin
          ok_d    = 1'b0;
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= 3'd0;
      tries_q <= 3'd0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
      ok_q    <= 1'b0;
      addr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      tries_q <= tries_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      ok_q    <= ok_d;
      addr_q  <= sysid_address;
    end
  end

  assign id_value = id_q;
  assign ts_value = ts_q;
  assign busy     = (state_q != IDLE) && (state_q != FIN);
  assign done     = (state_q == FIN);
  assign id_ok    = ok_q;
  assign tries    = tries_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker: a zero-latency DUT with a fault-injecting slave and a latency-2 DUT.
module tb_sysid_boot_checker;

  localparam logic [31:0] TS_WORD = 32'd1455550170;
`ifdef SYSID_CHECK_TS_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif
  localparam int PER   = TS_EN ? 3 : 2;   // cycles per attempt at latency 0
  localparam int E_DONE = PER + 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start2 = 1'b0;
  logic        addr0, read0, busy0, done0, ok0;
  logic        addr2, read2, busy2, done2, ok2;
  logic [31:0] rdata0, rdata2, id0, ts0, id2, ts2;
  logic [2:0]  tries0, tries2;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_id_count = 0;
  int bad_until = 0;
  int rdc[4];
  logic rda[4];
  logic [1:0] p0 = 2'b00, p1 = 2'b00;

  always #5 clock = ~clock;

  sysid_boot_checker u_dut (
    .clock(clock), .reset(reset), .start(start0),
    .sysid_address(addr0), .sysid_read(read0), .sysid_readdata(rdata0),
    .id_value(id0), .ts_value(ts0), .busy(busy0), .done(done0),
    .id_ok(ok0), .tries(tries0)
  );

  sysid_boot_checker #(.READ_LATENCY(2)) u_lat (
    .clock(clock), .reset(reset), .start(start2),
    .sysid_address(addr2), .sysid_read(read2), .sysid_readdata(rdata2),
    .id_value(id2), .ts_value(ts2), .busy(busy2), .done(done2),
    .id_ok(ok2), .tries(tries2)
  );

  // Zero-latency slave: ID reads return 5 until rd_id_count reaches bad_until.
  assign rdata0 = addr0 ? TS_WORD : ((rd_id_count < bad_until) ? 32'h5 : 32'h0);
  always @(posedge clock) if (read0 && !addr0) rd_id_count <= rd_id_count + 1;

  // Two-cycle slave: data valid only two cycles after the strobe, garbage otherwise.
  always @(posedge clock) begin
    p1 <= p0;
    p0 <= {read2, addr2};
  end
  assign rdata2 = p1[1] ? (p1[0] ? TS_WORD : 32'h0) : 32'hDEADBEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic run0(input int busy_start_at, output int cyc, output int nreads);
    start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    cyc = 1;
    nreads = 0;
    while (!done0 && cyc < 60) begin
      if (read0) begin
        if (nreads < 4) begin
          rdc[nreads] = cyc;
          rda[nreads] = addr0;
        end
        nreads++;
      end
      if (cyc == busy_start_at) start0 = 1'b1;
      @(posedge clock); #1;
      start0 = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    int cyc, nr;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_tries", 32'(tries0), 32'd0);
    check("rst_id", id0, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Nominal check
    bad_until = rd_id_count;
    run0(-1, cyc, nr);
    check("nom_done_cyc", 32'(cyc), 32'(E_DONE));
    check("nom_reads", 32'(nr), 32'(TS_EN ? 2 : 1));
    check("nom_rd0_cyc", 32'(rdc[0]), 32'd1);
    check("nom_rd0_addr", 32'(rda[0]), 32'd0);
    if (TS_EN != 0) begin
      check("nom_rd1_cyc", 32'(rdc[1]), 32'd2);
      check("nom_rd1_addr", 32'(rda[1]), 32'd1);
    end
    check("nom_ok", 32'(ok0), 32'd1);
    check("nom_tries", 32'(tries0), 32'd1);
    check("nom_id", id0, 32'd0);
    check("nom_ts", ts0, TS_EN ? TS_WORD : 32'd0);
    check("nom_addr_hold", 32'(addr0), 32'(TS_EN));
    repeat (3) @(posedge clock);
    #1;
    check("fin_hold_done", 32'(done0), 32'd1);
    check("fin_hold_tries", 32'(tries0), 32'd1);

    // ID always wrong -> exhaust attempts
    bad_until = rd_id_count + 100;
    run0(-1, cyc, nr);
    check("bad_done_cyc", 32'(cyc), 32'(3 * PER + 1));
    check("bad_reads", 32'(nr), 32'(3 * (TS_EN ? 2 : 1)));
    check("bad_ok", 32'(ok0), 32'd0);
    check("bad_tries", 32'(tries0), 32'd3);
    check("bad_id", id0, 32'h5);

    // Reset on the read cycle, with start also high
    bad_until = rd_id_count;
    start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    check("mid_read", 32'(read0), 32'd1);
    reset = 1'b1;
    start0 = 1'b1;
    @(posedge clock); #1;
    check("mrst_busy", 32'(busy0), 32'd0);
    check("mrst_done", 32'(done0), 32'd0);
    check("mrst_ok", 32'(ok0), 32'd0);
    check("mrst_tries", 32'(tries0), 32'd0);
    check("mrst_id", id0, 32'd0);
    check("mrst_ts", ts0, 32'd0);
    check("mrst_read", 32'(read0), 32'd0);
    check("mrst_addr", 32'(addr0), 32'd0);
    reset = 1'b0;
    start0 = 1'b0;
    @(posedge clock); #1;
    check("post_rst_idle", 32'(busy0), 32'd0);
    @(posedge clock); #1;
    run0(-1, cyc, nr);
    check("post_rst_cyc", 32'(cyc), 32'(E_DONE));
    check("post_rst_ok", 32'(ok0), 32'd1);

    // ID wrong on first attempt only
    bad_until = rd_id_count + 1;
    run0(-1, cyc, nr);
    check("retry_done_cyc", 32'(cyc), 32'(2 * PER + 1));
    check("retry_ok", 32'(ok0), 32'd1);
    check("retry_tries", 32'(tries0), 32'd2);

    // start while busy must be ignored
    bad_until = rd_id_count;
    run0(2, cyc, nr);
    check("busy_start_cyc", 32'(cyc), 32'(E_DONE));
    check("busy_start_tries", 32'(tries0), 32'd1);
    check("busy_start_ok", 32'(ok0), 32'd1);

    // Latency-2 DUT
    start2 = 1'b1;
    @(posedge clock); #1;
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("lat_done_cyc", 32'(cyc), 32'(TS_EN ? 8 : 5));
    check("lat_ok", 32'(ok2), 32'd1);
    check("lat_id", id2, 32'd0);
    check("lat_ts", ts2, TS_EN ? TS_WORD : 32'd0);
    check("lat_tries", 32'(tries2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
